// File: rtl/weight_buffer.sv
// Weight buffer: loads a configured number of weights from the GLB fill stream, then serves
// WCA read addresses with 1-cycle latency through a 2-entry output FIFO that absorbs back-pressure.
module weight_buffer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned WEI_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      TOPWBF_CfgVld,
    input  logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgNum,
    output logic                      WBFTOP_CfgRdy,
    input  logic                      GLBWBF_DatVld,
    input  logic [DATA_WIDTH-1:0]     GLBWBF_Dat,
    output logic                      WBFGLB_DatRdy,
    input  logic                      WCAWBF_AdrVld,
    input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
    output logic                      WBFWCA_AdrRdy,
    output logic                      WBFWCA_DatVld,
    output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
    input  logic                      WCAWBF_DatRdy
);

    localparam int unsigned DEPTH = 2 ** WEI_ADDR_WIDTH;
    localparam int unsigned CW    = WEI_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WORK = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           num_cfg;
    logic [CW-1:0]           wr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_q;
    logic                    rd_pend;
    logic [DATA_WIDTH-1:0]   fifo [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fcnt;

    logic fill_hs;
    logic adr_hs;
    logic abort;
    logic push;
    logic pop;
    logic in_range;

    // Next state and handshake outputs; every output depends on registers only.
    always_comb begin
        state_nxt     = state;
        WBFTOP_CfgRdy = 1'b0;
        WBFGLB_DatRdy = 1'b0;
        WBFWCA_AdrRdy = 1'b0;
        WBFWCA_DatVld = 1'b0;
        WBFWCA_Dat    = '0;
        unique case (state)
            IDLE: begin
                WBFTOP_CfgRdy = 1'b1;
                if (TOPWBF_CfgVld) state_nxt = LOAD;
            end
            LOAD: begin
                WBFGLB_DatRdy = (wr_cnt < num_cfg);
                if (wr_cnt == num_cfg) state_nxt = WORK;
            end
            WORK: begin
                // fcnt + rd_pend < 2 leaves room for the word each accepted address will return
                WBFWCA_AdrRdy = ((fcnt + {1'b0, rd_pend}) < 2'd2);
                WBFWCA_DatVld = (fcnt != 2'd0) || rd_pend;
                if (fcnt != 2'd0)  WBFWCA_Dat = fifo[rd_ptr];
                else if (rd_pend)  WBFWCA_Dat = mem_q;
                if (TOPWBF_CfgVld) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fill_hs  = GLBWBF_DatVld & WBFGLB_DatRdy;
    assign adr_hs   = WCAWBF_AdrVld & WBFWCA_AdrRdy;
    assign abort    = (state == WORK) & TOPWBF_CfgVld;
    assign pop      = (fcnt != 2'd0) & WCAWBF_DatRdy;
    assign push     = rd_pend & ((fcnt != 2'd0) | ~WCAWBF_DatRdy);
    assign in_range = ({1'b0, WCAWBF_Adr} < num_cfg);

    // State register, configuration and fill counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            num_cfg <= '0;
            wr_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && TOPWBF_CfgVld) begin
                num_cfg <= TOPWBF_CfgNum;
                wr_cnt  <= '0;
            end else if (fill_hs) begin
                wr_cnt <= wr_cnt + CW'(1);
            end
        end
    end

    // Read stage and output FIFO bookkeeping; abort discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            rd_pend <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            fcnt    <= 2'd0;
        end else if (abort) begin
            rd_pend <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            fcnt    <= 2'd0;
        end else begin
            rd_pend <= adr_hs;
            if (adr_hs) mem_q <= in_range ? mem[WCAWBF_Adr] : '0;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   fcnt <= fcnt + 2'd1;
                2'b01:   fcnt <= fcnt - 2'd1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    // Storage arrays carry no reset
    always_ff @(posedge clk) begin
        if (fill_hs) mem[wr_cnt[WEI_ADDR_WIDTH-1:0]] <= GLBWBF_Dat;
        if (push && !abort) fifo[wr_ptr] <= mem_q;
    end

endmodule

// File: tb/tb_weight_buffer.sv
// Directed self-checking bench for weight_buffer: load, streaming, back-pressure, range, abort, reset.
module tb_weight_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_vld = 1'b0;
    logic [8:0] cfg_num = '0;
    logic       cfg_rdy;
    logic       glb_vld = 1'b0;
    logic [7:0] glb_dat = '0;
    logic       glb_rdy;
    logic       adr_vld = 1'b0;
    logic [7:0] adr = '0;
    logic       adr_rdy;
    logic       dat_vld;
    logic [7:0] dat;
    logic       dat_rdy = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    weight_buffer #(.DATA_WIDTH(8), .WEI_ADDR_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .TOPWBF_CfgVld (cfg_vld),
        .TOPWBF_CfgNum (cfg_num),
        .WBFTOP_CfgRdy (cfg_rdy),
        .GLBWBF_DatVld (glb_vld),
        .GLBWBF_Dat    (glb_dat),
        .WBFGLB_DatRdy (glb_rdy),
        .WCAWBF_AdrVld (adr_vld),
        .WCAWBF_Adr    (adr),
        .WBFWCA_AdrRdy (adr_rdy),
        .WBFWCA_DatVld (dat_vld),
        .WBFWCA_Dat    (dat),
        .WCAWBF_DatRdy (dat_rdy)
    );

    // Starts a load from IDLE and feeds seed+i until the block reaches WORK (AdrRdy rises).
    task automatic do_load(input int num, input logic [7:0] seed, output int cycles, output int rdy_cnt);
        int idx = 0;
        cycles  = 0;
        rdy_cnt = 0;
        cfg_num = 9'(num);
        cfg_vld = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;
        glb_vld = 1'b1;
        while (adr_rdy !== 1'b1 && cycles < 600) begin
            cycles++;
            if (glb_rdy === 1'b1) begin
                glb_dat = seed + 8'(idx);
                idx++;
                rdy_cnt++;
            end
            @(negedge clk);
        end
        glb_vld = 1'b0;
    endtask

    // Issues one address with DatRdy=1 and returns what is presented the next cycle.
    task automatic read_one(input logic [7:0] a, output logic v, output logic [7:0] d);
        int w = 0;
        dat_rdy = 1'b1;
        while (adr_rdy !== 1'b1 && w < 20) begin
            w++;
            @(negedge clk);
        end
        adr     = a;
        adr_vld = 1'b1;
        @(negedge clk);
        adr_vld = 1'b0;
        v = dat_vld;
        d = dat;
    endtask

    task automatic go_idle();
        cfg_vld = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (cfg_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_rdy got %b expected 1", cfg_rdy); end
        n_checks++; if (glb_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_glb_rdy got %b expected 0", glb_rdy); end
        n_checks++; if (adr_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_adr_rdy got %b expected 0", adr_rdy); end
        n_checks++; if (dat_vld !== 1'b0) begin n_fail++; $display("FAIL reset_dat_vld got %b expected 0", dat_vld); end
        n_checks++; if (dat !== 8'h00) begin n_fail++; $display("FAIL reset_dat got %h expected 00", dat); end
    endtask

    task automatic test_load();
        int cyc, rdy;
        logic v;
        logic [7:0] d;
        do_load(4, 8'hA0, cyc, rdy);
        n_checks++; if (rdy !== 4) begin n_fail++; $display("FAIL load_datrdy_cycles got %0d expected 4", rdy); end
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL load_cycles_to_work got %0d expected 5", cyc); end
        n_checks++; if (cfg_rdy !== 1'b0) begin n_fail++; $display("FAIL load_cfg_rdy_work got %b expected 0", cfg_rdy); end
        read_one(8'd2, v, d);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL load_read2_vld got %b expected 1", v); end
        n_checks++; if (d !== 8'hA2) begin n_fail++; $display("FAIL load_read2_dat got %h expected a2", d); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 5; i++) begin
            dat_rdy = 1'b1;
            adr_vld = (i < 4);
            adr     = 8'(i);
            if (i < 4) begin
                n_checks++; if (adr_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_adr_rdy[%0d] got %b expected 1", i, adr_rdy); end
            end
            if (i > 0) begin
                n_checks++; if (dat_vld !== 1'b1) begin n_fail++; $display("FAIL stream_vld[%0d] got %b expected 1", i, dat_vld); end
                n_checks++; if (dat !== 8'hA0 + 8'(i - 1)) begin n_fail++; $display("FAIL stream_dat[%0d] got %h expected %h", i, dat, 8'hA0 + 8'(i - 1)); end
            end
            @(negedge clk);
        end
        adr_vld = 1'b0;
        n_checks++; if (dat_vld !== 1'b0) begin n_fail++; $display("FAIL stream_idle_vld got %b expected 0", dat_vld); end
    endtask

    task automatic test_backpressure();
        logic [6:0] t_avld = 7'b0011111;
        logic [6:0] t_drdy = 7'b1111000;
        logic [6:0] e_ardy = 7'b1110011;
        logic [6:0] e_vld  = 7'b0111110;
        logic [7:0] t_adr [7] = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd0, 8'd0};
        logic [7:0] e_dat [7] = '{8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'h00};
        for (int c = 0; c < 7; c++) begin
            adr_vld = t_avld[c];
            adr     = t_adr[c];
            dat_rdy = t_drdy[c];
            n_checks++; if (adr_rdy !== e_ardy[c]) begin n_fail++; $display("FAIL bp_adr_rdy[%0d] got %b expected %b", c, adr_rdy, e_ardy[c]); end
            n_checks++; if (dat_vld !== e_vld[c]) begin n_fail++; $display("FAIL bp_vld[%0d] got %b expected %b", c, dat_vld, e_vld[c]); end
            n_checks++; if (dat !== e_dat[c]) begin n_fail++; $display("FAIL bp_dat[%0d] got %h expected %h", c, dat, e_dat[c]); end
            @(negedge clk);
        end
        adr_vld = 1'b0;
        dat_rdy = 1'b1;
    endtask

    task automatic test_out_of_range();
        logic v;
        logic [7:0] d;
        read_one(8'd7, v, d);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL oor_vld got %b expected 1", v); end
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL oor_dat got %h expected 00", d); end
        read_one(8'd4, v, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL oor_edge4_dat got %h expected 00", d); end
        read_one(8'd3, v, d);
        n_checks++; if (d !== 8'hA3) begin n_fail++; $display("FAIL oor_last_dat got %h expected a3", d); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int cyc, rdy;
        logic v;
        logic [7:0] d;
        dat_rdy = 1'b0;
        adr_vld = 1'b1; adr = 8'd0;
        @(negedge clk);
        adr = 8'd1;
        @(negedge clk);
        adr_vld = 1'b0;
        @(negedge clk);
        n_checks++; if (adr_rdy !== 1'b0) begin n_fail++; $display("FAIL abort_full_adr_rdy got %b expected 0", adr_rdy); end
        n_checks++; if (dat !== 8'hA0) begin n_fail++; $display("FAIL abort_full_head got %h expected a0", dat); end
        cfg_vld = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;
        n_checks++; if (cfg_rdy !== 1'b1) begin n_fail++; $display("FAIL abort_cfg_rdy got %b expected 1", cfg_rdy); end
        n_checks++; if (dat_vld !== 1'b0) begin n_fail++; $display("FAIL abort_dat_vld got %b expected 0", dat_vld); end
        n_checks++; if (dat !== 8'h00) begin n_fail++; $display("FAIL abort_dat got %h expected 00", dat); end
        n_checks++; if (adr_rdy !== 1'b0) begin n_fail++; $display("FAIL abort_adr_rdy got %b expected 0", adr_rdy); end
        dat_rdy = 1'b1;
        do_load(1, 8'h5C, cyc, rdy);
        n_checks++; if (rdy !== 1) begin n_fail++; $display("FAIL abort_reload_rdy got %0d expected 1", rdy); end
        read_one(8'd0, v, d);
        n_checks++; if (v !== 1'b1 || d !== 8'h5C) begin n_fail++; $display("FAIL abort_new_word got %b/%h expected 1/5c", v, d); end
        read_one(8'd1, v, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL abort_new_oor got %h expected 00", d); end
        @(negedge clk);
    endtask

    task automatic test_zero_load();
        int cyc, rdy;
        logic v;
        logic [7:0] d;
        go_idle();
        do_load(0, 8'h00, cyc, rdy);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL zero_load_cycles got %0d expected 1", cyc); end
        n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL zero_load_writes got %0d expected 0", rdy); end
        read_one(8'd0, v, d);
        n_checks++; if (v !== 1'b1 || d !== 8'h00) begin n_fail++; $display("FAIL zero_load_read got %b/%h expected 1/00", v, d); end
        @(negedge clk);
    endtask

    task automatic test_full_depth();
        int cyc, rdy;
        logic v;
        logic [7:0] d;
        go_idle();
        do_load(256, 8'h10, cyc, rdy);
        n_checks++; if (rdy !== 256) begin n_fail++; $display("FAIL full_writes got %0d expected 256", rdy); end
        n_checks++; if (cyc !== 257) begin n_fail++; $display("FAIL full_cycles got %0d expected 257", cyc); end
        read_one(8'd255, v, d);
        n_checks++; if (d !== 8'h0F) begin n_fail++; $display("FAIL full_last got %h expected 0f", d); end
        read_one(8'd0, v, d);
        n_checks++; if (d !== 8'h10) begin n_fail++; $display("FAIL full_first got %h expected 10", d); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        go_idle();
        cfg_num = 9'd4;
        cfg_vld = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;
        glb_vld = 1'b1;
        glb_dat = 8'h11;
        @(negedge clk);
        glb_dat = 8'h22;
        @(negedge clk);
        n_checks++; if (glb_rdy !== 1'b1) begin n_fail++; $display("FAIL rml_mid_rdy got %b expected 1", glb_rdy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (cfg_rdy !== 1'b1) begin n_fail++; $display("FAIL rml_cfg_rdy got %b expected 1", cfg_rdy); end
        n_checks++; if (glb_rdy !== 1'b0) begin n_fail++; $display("FAIL rml_glb_rdy got %b expected 0", glb_rdy); end
        n_checks++; if (adr_rdy !== 1'b0 || dat_vld !== 1'b0 || dat !== 8'h00) begin
            n_fail++; $display("FAIL rml_read_side got %b/%b/%h expected 0/0/00", adr_rdy, dat_vld, dat);
        end
        glb_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cfg_rdy !== 1'b1 || glb_rdy !== 1'b0) begin
            n_fail++; $display("FAIL rml_after_release got %b/%b expected 1/0", cfg_rdy, glb_rdy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_load();
        test_streaming();
        test_backpressure();
        test_out_of_range();
        test_abort();
        test_zero_load();
        test_full_depth();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
